// File: rtl/ram_sweep_ctrl_if.sv
// RAM sweep controller bus: sweep requests and pattern select in, RAM strobes and status out.
interface ram_sweep_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              wr_flag;
  logic              rd_flag;
  logic [1:0]        pat_sel;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              err;

  // Controller side
  modport master (
    input  wr_flag, rd_flag, pat_sel, rd_data,
    output wr_en, rd_en, addr, wr_data, wr_done, err
  );

  // Requester / RAM side
  modport slave (
    output wr_flag, rd_flag, pat_sel, rd_data,
    input  wr_en, rd_en, addr, wr_data, wr_done, err
  );
endinterface

// File: rtl/ram_sweep_ctrl.sv
// RAM sweep controller: writes a pattern over DEPTH words, or reads them back
// repeatedly with a per-address dwell of CNT_MAX+1 cycles.
// Optional read-back checking is built when RAM_SWEEP_CHECK_EN is defined.
module ram_sweep_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned CNT_MAX = 24'd9_999_999,
  parameter int unsigned CNT_W   = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  ram_sweep_ctrl_if.master     bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_pat;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_wr_done;
  logic              w_accept_rd;

  // Data pattern for a given address
  function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] sel, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    case (sel)
      2'd0: v = DATA_W'(a);
      2'd1: v = ~DATA_W'(a);
      2'd2: for (int i = 0; i < int'(DATA_W); i++) v[i] = i[0] ? a[0] : ~a[0];
      default: v = '1;
    endcase
    return v;
  endfunction

  // rd_flag is ignored while writing and always loses to wr_flag
  assign w_accept_rd = bus.rd_flag && !bus.wr_flag && (r_state != S_WRITE);

  // Sweep FSM with registered RAM strobes, address and dwell counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_pat     <= 2'd0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      if (bus.wr_flag) begin
        r_state <= S_WRITE;
        r_wr_en <= 1'b1;
        r_rd_en <= 1'b0;
        r_addr  <= '0;
        r_cnt   <= '0;
        r_pat   <= bus.pat_sel;
      end else if (w_accept_rd) begin
        r_state <= S_READ;
        r_wr_en <= 1'b0;
        r_rd_en <= 1'b1;
        r_addr  <= '0;
        r_cnt   <= '0;
        r_pat   <= bus.pat_sel;
      end else begin
        case (r_state)
          S_WRITE: begin
            if (r_addr == LAST_ADDR) begin
              r_state   <= S_IDLE;
              r_wr_en   <= 1'b0;
              r_addr    <= '0;
              r_wr_done <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
          S_READ: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt  <= '0;
              r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.rd_en   = r_rd_en;
  assign bus.addr    = r_addr;
  assign bus.wr_done = r_wr_done;
  assign bus.wr_data = r_wr_en ? pat_f(r_pat, r_addr) : '0;

`ifdef RAM_SWEEP_CHECK_EN
  logic              r_err;
  logic              r_rd_en_d;
  logic [ADDR_W-1:0] r_addr_d;
  logic [1:0]        r_pat_d;
  logic              w_accept;

  assign w_accept = bus.wr_flag || w_accept_rd;

  // Compare returning read data against the pattern of the address issued last cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_err     <= 1'b0;
      r_rd_en_d <= 1'b0;
      r_addr_d  <= '0;
      r_pat_d   <= 2'd0;
    end else begin
      r_rd_en_d <= r_rd_en;
      r_addr_d  <= r_addr;
      r_pat_d   <= r_pat;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if ((r_state == S_READ) && r_rd_en_d &&
                   (bus.rd_data != pat_f(r_pat_d, r_addr_d))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^bus.rd_data;
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Self-checking bench for ram_sweep_ctrl (DEPTH=4, CNT_MAX=3) with a
// one-cycle-latency RAM model. Error expectations follow RAM_SWEEP_CHECK_EN.
module tb_ram_sweep_ctrl;

`ifdef RAM_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic corrupt = 1'b0;
  logic [7:0] mem [0:7];

  ram_sweep_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  ram_sweep_ctrl #(
    .ADDR_W(3), .DATA_W(8), .DEPTH(4), .CNT_MAX(3), .CNT_W(4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM model: synchronous write, registered read; word 2 can be corrupted on write
  always @(posedge sys_clk) begin
    if (bus.wr_en)
      mem[bus.addr] <= (corrupt && bus.addr == 3'd2) ? (bus.wr_data ^ 8'h01) : bus.wr_data;
    if (bus.rd_en)
      bus.rd_data <= mem[bus.addr];
  end

  typedef struct {
    logic       rst, wr, rd;
    logic [1:0] pat;
    logic       wen, ren;
    logic [2:0] addr;
    logic [7:0] wd;
    logic       done, err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  function automatic vec_t mk(input logic rst, wr, rd, input logic [1:0] pat,
                              input logic wen, ren, input logic [2:0] addr,
                              input logic [7:0] wd, input logic done, err);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.pat = pat;
    v.wen = wen; v.ren = ren; v.addr = addr; v.wd = wd; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", nm, n_step, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    sys_rst     = v.rst;
    bus.wr_flag = v.wr;
    bus.rd_flag = v.rd;
    bus.pat_sel = v.pat;
    sb.push_back(v);
    @(posedge sys_clk);
    #1;
    e = sb.pop_front();
    chk("wr_en",   8'(bus.wr_en),   8'(e.wen));
    chk("rd_en",   8'(bus.rd_en),   8'(e.ren));
    chk("addr",    8'(bus.addr),    8'(e.addr));
    chk("wr_data", bus.wr_data,     e.wd);
    chk("wr_done", 8'(bus.wr_done), 8'(e.done));
    chk("err",     8'(bus.err),     8'(e.err));
    n_step++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    bus.rd_data = 8'h00;
    bus.wr_flag = 1'b0;
    bus.rd_flag = 1'b0;
    bus.pat_sel = 2'd0;

    // reset, then idle
    tbl.push_back(mk(1,0,0,0, 0,0,0,8'h00,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,0,0));
    // write sweep, pattern 0; pat_sel wiggles mid-sweep without effect
    tbl.push_back(mk(0,1,0,0, 1,0,0,8'h00,0,0));
    tbl.push_back(mk(0,0,0,3, 1,0,1,8'h01,0,0));
    tbl.push_back(mk(0,0,0,2, 1,0,2,8'h02,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,3,8'h03,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,0,0));
    // read sweep from idle: each address held 4 cycles, wraps to 0
    tbl.push_back(mk(0,0,1,0, 0,1,0,8'h00,0,0));
    for (int k = 2; k <= 20; k++)
      tbl.push_back(mk(0,0,0,2'(k % 4), 0,1,3'(((k - 1) / 4) % 4),8'h00,0,0));
    // wr_flag and rd_flag together in READ: write wins, pattern 2
    tbl.push_back(mk(0,1,1,2, 1,0,0,8'h55,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,1,8'hAA,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,2,8'h55,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,3,8'hAA,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,1,0));
    // rd_flag during WRITE is ignored, pattern 3
    tbl.push_back(mk(0,1,0,3, 1,0,0,8'hFF,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,1,8'hFF,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,2,8'hFF,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,3,8'hFF,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,8'h00,0,0));

    @(posedge sys_clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // rd_flag inside READ restarts address and dwell
    apply(mk(0,0,1,3, 0,1,0,8'h00,0,0));
    for (int k = 2; k <= 6; k++) apply(mk(0,0,0,0, 0,1,3'((k - 1) / 4),8'h00,0,0));
    apply(mk(0,0,1,3, 0,1,0,8'h00,0,0));
    for (int k = 2; k <= 5; k++) apply(mk(0,0,0,0, 0,1,3'((k - 1) / 4),8'h00,0,0));

    // wr_flag inside WRITE at the last address restarts, no wr_done
    apply(mk(0,1,0,0, 1,0,0,8'h00,0,0));
    apply(mk(0,0,0,0, 1,0,1,8'h01,0,0));
    apply(mk(0,0,0,0, 1,0,2,8'h02,0,0));
    apply(mk(0,0,0,0, 1,0,3,8'h03,0,0));
    apply(mk(0,1,0,1, 1,0,0,8'hFF,0,0));
    apply(mk(0,0,0,0, 1,0,1,8'hFE,0,0));
    apply(mk(0,0,0,0, 1,0,2,8'hFD,0,0));
    apply(mk(0,0,0,0, 1,0,3,8'hFC,0,0));
    apply(mk(0,0,0,0, 0,0,0,8'h00,1,0));

    // reset mid-sweep at address 2; flags during reset are dropped
    apply(mk(0,1,0,1, 1,0,0,8'hFF,0,0));
    apply(mk(0,0,0,0, 1,0,1,8'hFE,0,0));
    apply(mk(0,0,0,0, 1,0,2,8'hFD,0,0));
    apply(mk(1,0,0,0, 0,0,0,8'h00,0,0));
    apply(mk(1,1,1,2, 0,0,0,8'h00,0,0));
    apply(mk(0,0,0,0, 0,0,0,8'h00,0,0));
    apply(mk(0,0,0,0, 0,0,0,8'h00,0,0));

    // corrupted word 2: err rises while reading address 2, sticks, clears on rd_flag
    corrupt = 1'b1;
    apply(mk(0,1,0,1, 1,0,0,8'hFF,0,0));
    apply(mk(0,0,0,0, 1,0,1,8'hFE,0,0));
    apply(mk(0,0,0,0, 1,0,2,8'hFD,0,0));
    apply(mk(0,0,0,0, 1,0,3,8'hFC,0,0));
    apply(mk(0,0,0,0, 0,0,0,8'h00,1,0));
    corrupt = 1'b0;
    apply(mk(0,0,1,1, 0,1,0,8'h00,0,0));
    for (int k = 2; k <= 20; k++)
      apply(mk(0,0,0,0, 0,1,3'(((k - 1) / 4) % 4),8'h00,0,CHK && (k >= 11)));
    apply(mk(0,0,1,1, 0,1,0,8'h00,0,0));
    apply(mk(0,0,0,0, 0,1,0,8'h00,0,0));
    apply(mk(0,1,0,0, 1,0,0,8'h00,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
